// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared memory constants and mem_dumper state encoding (MEM_DUMPER_CHECKSUM_EN adds ST_CSUM)
package chip8_pkg;

  localparam int          MEM_SIZE  = 4096;
  localparam logic [11:0] PROG_BASE = 12'h200;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_LAT  = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
`ifdef MEM_DUMPER_CHECKSUM_EN
    ,
    ST_CSUM = 3'd5
`endif
  } dump_state_t;

endpackage

// File: rtl/mem_dumper.sv
// rtl/mem_dumper.sv - streams a memory window out byte by byte; MEM_DUMPER_CHECKSUM_EN appends a mod-256 sum byte
module mem_dumper
  import chip8_pkg::*;
#(
  parameter int ADDR_W = $clog2(MEM_SIZE),
  parameter int DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic [ADDR_W:0]   length_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              mem_rd_en_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] tx_data_out,
  output logic              tx_valid_out,
  input  logic              tx_ready_in,
  output logic              tx_last_out
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  dump_state_t       r_state;
  dump_state_t       w_next_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_index;
  logic [DATA_W-1:0] r_tx_data;

  logic              w_start_ok;
  logic              w_hs;
  logic              w_final;
  logic [ADDR_W:0]   w_index_inc;
  logic [ADDR_W:0]   w_len_clamped;

  assign w_start_ok    = (r_state == ST_IDLE) && start_in;
  assign w_hs          = (r_state == ST_SEND) && tx_ready_in;
  assign w_index_inc   = r_index + ONE;
  assign w_final       = (w_index_inc >= r_len);
  assign w_len_clamped = (length_in > MAX_LEN) ? MAX_LEN : length_in;
  // Truncation to ADDR_W bits gives the wrap from the top of memory back to 0.
  assign mem_addr_out  = r_base + r_index[ADDR_W-1:0];

`ifdef MEM_DUMPER_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
  logic [DATA_W-1:0] w_csum_next;

  assign w_csum_next = r_csum + r_tx_data;

  // Running sum of every data byte accepted downstream.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_csum <= '0;
    end else if (w_start_ok) begin
      r_csum <= '0;
    end else if (w_hs) begin
      r_csum <= w_csum_next;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Dump bookkeeping and the outgoing byte, which only changes in LAT or on a handshake.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_base    <= '0;
      r_len     <= '0;
      r_index   <= '0;
      r_tx_data <= '0;
    end else if (w_start_ok) begin
      r_base    <= base_addr_in;
      r_len     <= w_len_clamped;
      r_index   <= '0;
      r_tx_data <= '0;
    end else if (r_state == ST_LAT) begin
      r_tx_data <= mem_data_in;
    end else if (w_hs) begin
      r_index <= w_index_inc;
`ifdef MEM_DUMPER_CHECKSUM_EN
      if (w_final) begin
        r_tx_data <= w_csum_next;
      end
`endif
    end
  end

  // Next-state and Moore outputs; a zero-length dump skips straight to the end.
  always_comb begin
    w_next_state  = r_state;
    busy_out      = (r_state != ST_IDLE);
    done_out      = 1'b0;
    mem_rd_en_out = 1'b0;
    tx_valid_out  = 1'b0;
    tx_last_out   = 1'b0;
    tx_data_out   = r_tx_data;
    case (r_state)
      ST_IDLE: begin
        if (start_in) begin
          if (w_len_clamped == '0) begin
`ifdef MEM_DUMPER_CHECKSUM_EN
            w_next_state = ST_CSUM;
`else
            w_next_state = ST_DONE;
`endif
          end else begin
            w_next_state = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        mem_rd_en_out = 1'b1;
        w_next_state  = ST_LAT;
      end
      ST_LAT: begin
        w_next_state = ST_SEND;
      end
      ST_SEND: begin
        tx_valid_out = 1'b1;
`ifndef MEM_DUMPER_CHECKSUM_EN
        tx_last_out = w_final;
`endif
        if (tx_ready_in) begin
          if (!w_final) begin
            w_next_state = ST_REQ;
          end else begin
`ifdef MEM_DUMPER_CHECKSUM_EN
            w_next_state = ST_CSUM;
`else
            w_next_state = ST_DONE;
`endif
          end
        end
      end
`ifdef MEM_DUMPER_CHECKSUM_EN
      ST_CSUM: begin
        tx_valid_out = 1'b1;
        tx_last_out  = 1'b1;
        if (tx_ready_in) begin
          w_next_state = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        done_out     = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/mem_dumper.md
MEM_DUMPER -- requirements
Module: mem_dumper

Interface
REQ-001 Parameter ADDR_W, default 12, memory address width (4096 bytes).
REQ-002 Parameter DATA_W, default 8, memory and stream byte width.
REQ-003 clk_in  input  1  single clock; all state updates on posedge.
REQ-004 rst_in  input  1  reset, asynchronous, active-low.
REQ-005 start_in  input  1  one-cycle pulse that begins a dump; sampled only in IDLE.
REQ-006 base_addr_in  input  ADDR_W  first byte address; sampled with start_in.
REQ-007 length_in  input  ADDR_W+1  byte count 0..4096; sampled with start_in.
REQ-008 busy_out  output  1  high from the cycle after an accepted start until done_out.
REQ-009 done_out  output  1  one-cycle pulse after the final stream handshake.
REQ-010 mem_rd_en_out  output  1  synchronous read strobe to memory.
REQ-011 mem_addr_out  output  ADDR_W  read address, valid with mem_rd_en_out.
REQ-012 mem_data_in  input  DATA_W  read data, valid exactly 1 cycle after mem_rd_en_out.
REQ-013 tx_data_out  output  DATA_W  stream byte.
REQ-014 tx_valid_out  output  1  stream byte valid.
REQ-015 tx_ready_in  input  1  downstream ready; handshake = valid & ready at posedge.
REQ-016 tx_last_out  output  1  marks the final byte of a dump; qualified by tx_valid_out.

Function
REQ-017 FSM states: IDLE, REQ, LAT, SEND, DONE.
REQ-018 IDLE: on start_in with length_in>0 -> REQ; with length_in==0 -> DONE (no bytes, unless REQ-031).
REQ-019 length_in>4096 clamped to 4096.
REQ-020 REQ: mem_rd_en_out=1, mem_addr_out=(base+index) mod 4096 -> LAT.
REQ-021 LAT: capture mem_data_in into tx_data_out; -> SEND.
REQ-022 SEND: tx_valid_out=1; tx_data_out and tx_last_out held stable until handshake.
REQ-023 SEND handshake: index+1; more bytes remaining -> REQ, else -> DONE.
REQ-024 DONE: done_out=1 for one cycle -> IDLE; busy_out low in IDLE.
REQ-025 Address wrap: 0xFFF+1 -> 0x000 with no gap or error (e.g. base 0xFFE, len 4 reads FFE, FFF, 000, 001).
REQ-026 start_in while not IDLE ignored; in-progress dump unaffected.
REQ-027 tx_last_out=1 only on the last byte emitted; never on other bytes.
REQ-028 mem_rd_en_out never asserted outside REQ; one read per byte, bytes in ascending address order.
REQ-029 Throughput 1 byte per 3 cycles at tx_ready_in held high; back-pressure stalls in SEND indefinitely.

Reset
REQ-030 rst_in low forces IDLE immediately (asynchronously), including mid-dump; all outputs 0 (busy, done, rd_en, addr, tx_data, tx_valid, tx_last), index and checksum cleared; no resumption on release.

Configuration
REQ-031 MEM_DUMPER_CHECKSUM_EN defined: after the last data byte, one extra byte = sum of all data bytes mod 256 is sent in state CSUM (SEND-like, between SEND and DONE); tx_last_out moves to the checksum byte; length 0 emits single byte 0x00 with tx_last_out.
REQ-032 MEM_DUMPER_CHECKSUM_EN undefined: no CSUM state, no accumulator; behaviour exactly per REQ-017..029.

Structure
REQ-033 Shared package chip8_pkg holds MEM_SIZE=4096, PROG_BASE=12'h200, and the mem_dumper state enum typedef.
REQ-034 No sub-module; checksum accumulator is inline under the macro.

Verification
REQ-035 Memory 0x200..0x203 = 12 34 56 78, start base 0x200 len 4, ready=1 -> bytes 12 34 56 78, last on 78, done 1 cycle after last handshake, 12 cycles total.
REQ-036 base 0xFFE len 4, memory FFE=AA FFF=BB 000=CC 001=DD -> stream AA BB CC DD, rd addresses FFE FFF 000 001.
REQ-037 ready toggled 0/1 pseudo-randomly during len 8 -> tx_data/tx_last stable while valid&!ready, 8 bytes in order, no duplicates.
REQ-038 len 0 -> no tx_valid, done pulse; with checksum macro: one byte 0x00 with last. Len 4 of REQ-035 with macro -> fifth byte 0x14, last on it only.
REQ-039 rst_in low during 3rd byte of len 16 -> all outputs 0 same cycle; after release idle until new start; start pulsed while busy -> ignored.
